// File: rtl/latch_write_sequencer.sv
// Initiator for a bank of transparent latches sharing one data bus.
// Each accepted write is sequenced as data setup, enable pulse, data hold, then done.
module latch_write_sequencer #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned N_LATCH   = 4,
  parameter int unsigned ADDR_W    = 2,
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned HOLD_CYC  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [DATA_W-1:0]  req_data,
  output logic [DATA_W-1:0]  lat_d,
  output logic [N_LATCH-1:0] lat_en,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int unsigned MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int unsigned MAX_CYC = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [ADDR_W-1:0]   cap_addr;
  logic                cap_ok;
  logic                accept;
  logic                addr_ok;
  logic [DATA_W-1:0]   lat_d_nxt;
  logic [N_LATCH-1:0]  lat_en_nxt;
  logic                busy_nxt, done_nxt, err_nxt;

  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign addr_ok   = 32'(req_addr) < N_LATCH;

  // State, counter, captured request and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      cap_addr <= '0;
      cap_ok   <= 1'b0;
      lat_d    <= '0;
      lat_en   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      lat_d  <= lat_d_nxt;
      lat_en <= lat_en_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
      err    <= err_nxt;
      if (accept) begin
        cap_addr <= req_addr;
        cap_ok   <= addr_ok;
      end
    end
  end

  // Next state; the counter is reloaded with the phase length on every state entry
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SETUP;
          cnt_nxt   = CNT_W'(SETUP_CYC - 1);
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_nxt = PULSE;
          cnt_nxt   = CNT_W'(PULSE_CYC - 1);
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      PULSE: begin
        if (cnt == '0) begin
          state_nxt = HOLD;
          cnt_nxt   = CNT_W'(HOLD_CYC - 1);
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Next output values; data moves only on accept, enable only while in PULSE
  always_comb begin
    lat_d_nxt  = lat_d;
    lat_en_nxt = '0;
    busy_nxt   = (state_nxt != IDLE);
    done_nxt   = 1'b0;
    err_nxt    = 1'b0;
    if (accept) begin
      lat_d_nxt = req_data;
    end
    if (state_nxt == PULSE && cap_ok) begin
      lat_en_nxt = N_LATCH'(1) << cap_addr;
    end
    if (state == HOLD && state_nxt == IDLE) begin
      done_nxt = 1'b1;
      err_nxt  = !cap_ok;
    end
  end

endmodule
